// File: rtl/cnt_cmd_driver.sv
// cnt_cmd_driver: buffers LOAD/UP/DOWN/HOLD commands and sequences them onto a counter_ud
// control interface while modelling the expected count. Define CNT_CMD_DRIVER_CHECK_EN for the err checker.
module cnt_cmd_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             cnt_rstn,
    output logic             cnt_load_en,
    output logic [WIDTH-1:0] cnt_load,
    output logic             cnt_down,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_rollover,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] exp_count,
    output logic             err
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic             pend_q, pend_d;

    logic             rstn_q;
    logic             load_en_q, load_en_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             down_q, down_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             done_q, done_d;

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH+1:0] fifo_mem_q [DEPTH];
    logic             full, empty, push, pop;
    op_e              head_op, sel_op;
    logic [WIDTH-1:0] head_arg, sel_arg;
    logic             start, last;

    function automatic logic [WIDTH-1:0] steps_for(input op_e op, input logic [WIDTH-1:0] arg);
        if (op == OP_LOAD || arg == '0) begin
            return WIDTH'(1);
        end
        return arg;
    endfunction

    // FIFO
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = rstn_q & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign head_op   = op_e'(fifo_mem_q[rd_ptr_q[AW-1:0]][WIDTH+1:WIDTH]);
    assign head_arg  = fifo_mem_q[rd_ptr_q[AW-1:0]][WIDTH-1:0];
    assign wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_arg};
        end
    end

    // A command popped as EXEC finishes is parked in op_q/arg_q (pend_q) and started
    // after one hold cycle; an idle FSM starts straight from the FIFO head.
    assign sel_op  = (state_q == S_IDLE && !pend_q) ? head_op  : op_q;
    assign sel_arg = (state_q == S_IDLE && !pend_q) ? head_arg : arg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            steps_q <= '0;
            op_q    <= OP_HOLD;
            arg_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        op_d    = op_q;
        arg_d   = arg_q;
        pend_d  = pend_q;
        pop     = 1'b0;
        start   = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q || !empty) begin
                    start   = 1'b1;
                    pop     = !pend_q;
                    pend_d  = 1'b0;
                    op_d    = sel_op;
                    arg_d   = sel_arg;
                    steps_d = steps_for(sel_op, sel_arg);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (steps_q == WIDTH'(1)) begin
                    last    = 1'b1;
                    state_d = S_IDLE;
                    if (!empty) begin
                        pop    = 1'b1;
                        pend_d = 1'b1;
                        op_d   = head_op;
                        arg_d  = head_arg;
                    end
                end else begin
                    steps_d = steps_q - WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (!rstn_q) begin
            exp_d = '0;
        end else if (load_en_q) begin
            exp_d = load_q;
        end else if (down_q) begin
            exp_d = exp_q - WIDTH'(1);
        end else begin
            exp_d = exp_q + WIDTH'(1);
        end
    end

    // Default drive is a hold: reload the value the counter will have after this edge.
    always_comb begin
        load_en_d = 1'b1;
        load_d    = exp_d;
        down_d    = 1'b0;
        done_d    = last;
        if (start || (state_q == S_EXEC && !last)) begin
            case (sel_op)
                OP_LOAD: load_d = sel_arg;
                OP_UP:   load_en_d = (sel_arg == '0);
                OP_DOWN: begin
                    load_en_d = (sel_arg == '0);
                    down_d    = (sel_arg != '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstn_q    <= 1'b0;
            load_en_q <= 1'b1;
            load_q    <= '0;
            down_q    <= 1'b0;
            exp_q     <= '0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            rstn_q    <= 1'b1;
            load_en_q <= load_en_d;
            load_q    <= load_d;
            down_q    <= down_d;
            exp_q     <= exp_d;
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

`ifdef CNT_CMD_DRIVER_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (rstn_q && ((cnt_count != exp_q) || (cnt_rollover != &exp_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{cnt_count, cnt_rollover};
    assign err = 1'b0;
`endif

    assign cnt_rstn    = rstn_q;
    assign cnt_load_en = load_en_q;
    assign cnt_load    = load_q;
    assign cnt_down    = down_q;
    assign busy        = !empty || (state_q == S_EXEC) || pend_q;
    assign done        = done_q;
    assign exp_count   = exp_q;

endmodule

// File: tb/tb_cnt_cmd_driver.sv
// Directed bench for cnt_cmd_driver with a behavioural counter_ud on its control pins.
module tb_cnt_cmd_driver;
    localparam int W = 4;
    localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, HOLD = 2'b11;
`ifdef CNT_CMD_DRIVER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_arg = '0;
    logic         cnt_rstn, cnt_load_en, cnt_down, cnt_rollover;
    logic [W-1:0] cnt_load, cnt_count, exp_count;
    logic         busy, done, err;

    logic [W-1:0] ctr_q;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    logic [W-1:0] log_q [$];

    always #5 clk = ~clk;

    cnt_cmd_driver #(.WIDTH(W), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cnt_rstn(cnt_rstn), .cnt_load_en(cnt_load_en), .cnt_load(cnt_load), .cnt_down(cnt_down),
        .cnt_count(cnt_count), .cnt_rollover(cnt_rollover),
        .busy(busy), .done(done), .exp_count(exp_count), .err(err)
    );

    always_ff @(posedge clk or negedge cnt_rstn) begin
        if (!cnt_rstn)        ctr_q <= '0;
        else if (cnt_load_en) ctr_q <= cnt_load;
        else if (cnt_down)    ctr_q <= ctr_q - 4'd1;
        else                  ctr_q <= ctr_q + 4'd1;
    end
    assign cnt_count    = force_en ? force_val : ctr_q;
    assign cnt_rollover = &ctr_q;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic issue(input logic [1:0] op, input logic [W-1:0] arg, output int stalls);
        bit   acc = 1'b0;
        logic rdy;
        stalls = 0;
        cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) acc = 1'b1; else stalls++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL issue_accept: op=%0d arg=%0h not accepted in 50 cycles", op, arg); end
    endtask

    task automatic run_until_idle(input int budget, output int cycles);
        bit           idle = 1'b0;
        logic [W-1:0] prev = cnt_count;
        cycles = 0;
        log_q.delete();
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            cycles++;
            if (cnt_count !== prev) begin log_q.push_back(cnt_count); prev = cnt_count; end
            if (busy === 1'b0) idle = 1'b1;
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL run_idle: busy still %0b after %0d cycles", busy, budget); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cnt_rstn !== 1'b0)    begin errors++; $display("FAIL rst_cnt_rstn: got %0b want 0", cnt_rstn); end
        checks++; if (cnt_load_en !== 1'b1) begin errors++; $display("FAIL rst_load_en: got %0b want 1", cnt_load_en); end
        checks++; if (cnt_load !== 4'h0)    begin errors++; $display("FAIL rst_load: got %0h want 0", cnt_load); end
        checks++; if (cnt_down !== 1'b0)    begin errors++; $display("FAIL rst_down: got %0b want 0", cnt_down); end
        checks++; if (cmd_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready: got %0b want 0", cmd_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
        checks++; if (exp_count !== 4'h0)   begin errors++; $display("FAIL rst_exp: got %0h want 0", exp_count); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cnt_rstn !== 1'b0)  begin errors++; $display("FAIL rel_rstn_low: got %0b want 0", cnt_rstn); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_low: got %0b want 0", cmd_ready); end
        @(posedge clk); #1;
        checks++; if (cnt_rstn !== 1'b1)  begin errors++; $display("FAIL rel_rstn_high: got %0b want 1", cnt_rstn); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_high: got %0b want 1", cmd_ready); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cnt_count !== 4'h0) begin errors++; $display("FAIL idle_count: got %0h want 0", cnt_count); end
        checks++; if (exp_count !== 4'h0) begin errors++; $display("FAIL idle_exp: got %0h want 0", exp_count); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL idle_err: got %0b want 0", err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %0b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_up;
        logic [W-1:0] seq [4];
        int d0, st, cyc;
        seq = '{4'hC, 4'hD, 4'hE, 4'hF};
        d0 = done_seen;
        issue(LOAD, 4'hC, st);
        issue(UP, 4'd3, st);
        checks++; if (cnt_load_en !== 1'b1 || cnt_load !== 4'hC)
            begin errors++; $display("FAIL lu_first_drive: got load_en=%0b load=%0h want 1/c", cnt_load_en, cnt_load); end
        run_until_idle(40, cyc);
        checks++; if (log_q.size() != 4) begin errors++; $display("FAIL lu_seq_len: got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                checks++; if (log_q[i] !== seq[i]) begin errors++; $display("FAIL lu_seq[%0d]: got %0h want %0h", i, log_q[i], seq[i]); end
            end
        end
        checks++; if (done_seen - d0 != 2) begin errors++; $display("FAIL lu_dones: got %0d want 2", done_seen - d0); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cnt_count !== 4'hF) begin errors++; $display("FAIL lu_hold: got %0h want f", cnt_count); end
        checks++; if (cnt_load_en !== 1'b1 || cnt_load !== 4'hF)
            begin errors++; $display("FAIL lu_hold_drive: got load_en=%0b load=%0h want 1/f", cnt_load_en, cnt_load); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lu_err: got %0b want 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_down;
        logic [W-1:0] seq [3];
        int d0, st, cyc;
        seq = '{4'h1, 4'h0, 4'hF};
        d0 = done_seen;
        issue(LOAD, 4'h1, st);
        issue(DOWN, 4'd2, st);
        run_until_idle(40, cyc);
        checks++; if (log_q.size() != 3) begin errors++; $display("FAIL ld_seq_len: got %0d want 3", log_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < log_q.size()) begin
                checks++; if (log_q[i] !== seq[i]) begin errors++; $display("FAIL ld_seq[%0d]: got %0h want %0h", i, log_q[i], seq[i]); end
            end
        end
        checks++; if (exp_count !== 4'hF)  begin errors++; $display("FAIL ld_exp: got %0h want f", exp_count); end
        checks++; if (done_seen - d0 != 2) begin errors++; $display("FAIL ld_dones: got %0d want 2", done_seen - d0); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL ld_err: got %0b want 0", err); end
    endtask

    task automatic test_zero_and_hold;
        int d0, st, cyc;
        d0 = done_seen;
        issue(UP, 4'd0, st);
        run_until_idle(20, cyc);
        checks++; if (cyc != 3)            begin errors++; $display("FAIL up0_cycles: got %0d want 3", cyc); end
        checks++; if (log_q.size() != 0)   begin errors++; $display("FAIL up0_moved: got %0d changes want 0", log_q.size()); end
        checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL up0_dones: got %0d want 1", done_seen - d0); end
        d0 = done_seen;
        issue(HOLD, 4'd3, st);
        run_until_idle(20, cyc);
        checks++; if (cyc != 5)            begin errors++; $display("FAIL hold_cycles: got %0d want 5", cyc); end
        checks++; if (cnt_count !== 4'hF)  begin errors++; $display("FAIL hold_count: got %0h want f", cnt_count); end
        checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL hold_dones: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_back_to_back;
        int d0, st, cyc, stall_sum;
        issue(LOAD, 4'h0, st);
        run_until_idle(20, cyc);
        d0 = done_seen;
        stall_sum = 0;
        for (int k = 0; k < 5; k++) begin
            issue(UP, 4'd5, st);
            stall_sum += st;
        end
        checks++; if (stall_sum != 0)     begin errors++; $display("FAIL b2b_first5_stalls: got %0d want 0", stall_sum); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b want 0", cmd_ready); end
        issue(UP, 4'd5, st);
        checks++; if (st != 2)            begin errors++; $display("FAIL b2b_sixth_stalls: got %0d want 2", st); end
        run_until_idle(120, cyc);
        checks++; if (done_seen - d0 != 6) begin errors++; $display("FAIL b2b_dones: got %0d want 6", done_seen - d0); end
        checks++; if (cnt_count !== 4'hE)  begin errors++; $display("FAIL b2b_count: got %0h want e", cnt_count); end
        checks++; if (exp_count !== 4'hE)  begin errors++; $display("FAIL b2b_exp: got %0h want e", exp_count); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL b2b_ready_end: got %0b want 1", cmd_ready); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL b2b_err: got %0b want 0", err); end
    endtask

    task automatic test_checker;
        int st, cyc;
        issue(LOAD, 4'h5, st);
        run_until_idle(20, cyc);
        checks++; if (exp_count !== 4'h5) begin errors++; $display("FAIL chk_exp: got %0h want 5", exp_count); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL chk_err_pre: got %0b want 0", err); end
        force_val = 4'h3;
        force_en  = 1'b1;
        @(posedge clk); #1;
        force_en  = 1'b0;
        checks++; if (err !== ERR_EXP) begin errors++; $display("FAIL chk_err_set: got %0b want %0b", err, ERR_EXP); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (err !== ERR_EXP)    begin errors++; $display("FAIL chk_err_sticky: got %0b want %0b", err, ERR_EXP); end
        checks++; if (cnt_count !== 4'h5) begin errors++; $display("FAIL chk_count: got %0h want 5", cnt_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int d0, st;
        d0 = done_seen;
        issue(UP, 4'd10, st);
        issue(UP, 4'd1, st);
        issue(HOLD, 4'd2, st);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (cnt_count !== 4'h8) begin errors++; $display("FAIL abort_mid_count: got %0h want 8", cnt_count); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL abort_mid_busy: got %0b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (cnt_rstn !== 1'b0 || cnt_load_en !== 1'b1 || cnt_load !== 4'h0 || cnt_down !== 1'b0)
            begin errors++; $display("FAIL abort_ctl: got rstn=%0b le=%0b ld=%0h dn=%0b want 0/1/0/0", cnt_rstn, cnt_load_en, cnt_load, cnt_down); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL abort_status: got ready=%0b busy=%0b done=%0b want 0/0/0", cmd_ready, busy, done); end
        checks++; if (exp_count !== 4'h0 || err !== 1'b0)
            begin errors++; $display("FAIL abort_exp_err: got exp=%0h err=%0b want 0/0", exp_count, err); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (done_seen - d0 != 0) begin errors++; $display("FAIL abort_dones: got %0d want 0", done_seen - d0); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL abort_ready: got %0b want 1", cmd_ready); end
        checks++; if (cnt_count !== 4'h0 || exp_count !== 4'h0)
            begin errors++; $display("FAIL abort_count: got cnt=%0h exp=%0h want 0/0", cnt_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_load_up();
        test_load_down();
        test_zero_and_hold();
        test_back_to_back();
        test_checker();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
